cpu_control_unit: RTL and testbench

- Multicycle MIPS-subset control FSM that drives every datapath control wire of the cpu top: PCWrite, MemWrite, IRWrite, RegWrite, mux selects, ALU op and the pipeline-register write enables.
- Consumes opcode/funct from the instruction register and zero/overflow flags from the ALU.
- Handles variable memory latency via a wait counter.
- Raises an exception sequence on undefined instructions or arithmetic overflow.

---
 rtl/cpu_ctrl_pkg.sv | 98 +++++++++
 rtl/cpu_control_unit_decode.sv | 107 ++++++++++
 rtl/cpu_control_unit.sv | 99 +++++++++
 tb/tb_cpu_control_unit.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: states, opcodes,
// functs, datapath select codes and the packed control-word layout.
package cpu_ctrl_pkg;

  localparam logic [4:0] RST_ST    = 5'd0;
  localparam logic [4:0] FETCH     = 5'd1;
  localparam logic [4:0] FETCH_WB  = 5'd2;
  localparam logic [4:0] DECODE    = 5'd3;
  localparam logic [4:0] R_EXEC    = 5'd4;
  localparam logic [4:0] R_WB      = 5'd5;
  localparam logic [4:0] ADDI_EXEC = 5'd6;
  localparam logic [4:0] ADDI_WB   = 5'd7;
  localparam logic [4:0] MEM_ADDR  = 5'd8;
  localparam logic [4:0] LW_READ   = 5'd9;
  localparam logic [4:0] LW_MDR    = 5'd10;
  localparam logic [4:0] LW_WB     = 5'd11;
  localparam logic [4:0] SW_WRITE  = 5'd12;
  localparam logic [4:0] BRANCH    = 5'd13;
  localparam logic [4:0] JUMP      = 5'd14;
  localparam logic [4:0] JAL       = 5'd15;
  localparam logic [4:0] JR        = 5'd16;
  localparam logic [4:0] EXC       = 5'd17;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_PASS_A = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b001;
  localparam logic [2:0] ALU_SUB    = 3'b010;
  localparam logic [2:0] ALU_AND    = 3'b011;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] DSRC_ALUOUT = 2'b00;
  localparam logic [1:0] DSRC_MDR    = 2'b01;
  localparam logic [1:0] DSRC_PC     = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       ab_write;
    logic       alu_out_write;
    logic       mdr_write;
    logic       iord;
    logic [1:0] reg_dst;
    logic [1:0] data_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       exc;
  } ctrl_t;

  // Dispatch target out of DECODE; anything unrecognised traps.
  function automatic logic [4:0] decode_next(input logic [5:0] opcode, input logic [5:0] funct);
    logic [4:0] nxt;
    nxt = EXC;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND) nxt = R_EXEC;
        else if (funct == FN_JR) nxt = JR;
      end
      OP_ADDI:       nxt = ADDI_EXEC;
      OP_LW, OP_SW:  nxt = MEM_ADDR;
      OP_BEQ, OP_BNE: nxt = BRANCH;
      OP_J:          nxt = JUMP;
      OP_JAL:        nxt = JAL;
      default:       nxt = EXC;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/cpu_control_unit_decode.sv
// Combinational control-word decode of the FSM state; zero only matters in BRANCH
// and the wait counter only marks the first EXC cycle.
module ctrl_out_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] i_state,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  input  logic [2:0] i_wait_cnt,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
      end
      FETCH_WB: begin
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCS_ALU;
      end
      DECODE: begin
        o_ctrl.ab_write      = 1'b1;
        o_ctrl.alu_out_write = 1'b1;
        o_ctrl.alu_src_b     = SRCB_IMM_SH;
        o_ctrl.alu_op        = ALU_ADD;
      end
      R_EXEC: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_out_write = 1'b1;
        case (i_funct)
          FN_SUB:  o_ctrl.alu_op = ALU_SUB;
          FN_AND:  o_ctrl.alu_op = ALU_AND;
          default: o_ctrl.alu_op = ALU_ADD;
        endcase
      end
      R_WB: begin
        o_ctrl.reg_dst   = REGDST_RD;
        o_ctrl.data_src  = DSRC_ALUOUT;
        o_ctrl.reg_write = 1'b1;
      end
      ADDI_EXEC, MEM_ADDR: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_IMM;
        o_ctrl.alu_op        = ALU_ADD;
        o_ctrl.alu_out_write = 1'b1;
      end
      ADDI_WB: begin
        o_ctrl.reg_dst   = REGDST_RT;
        o_ctrl.reg_write = 1'b1;
      end
      LW_READ: o_ctrl.iord = 1'b1;
      LW_MDR: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mdr_write = 1'b1;
      end
      LW_WB: begin
        o_ctrl.reg_dst   = REGDST_RT;
        o_ctrl.data_src  = DSRC_MDR;
        o_ctrl.reg_write = 1'b1;
      end
      SW_WRITE: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      BRANCH: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALU_SUB;
        o_ctrl.pc_source = PCS_ALUOUT;
        o_ctrl.pc_write  = (i_opcode == OP_BEQ) ? i_zero : ~i_zero;
      end
      JUMP: begin
        o_ctrl.pc_source = PCS_JUMP;
        o_ctrl.pc_write  = 1'b1;
      end
      JAL: begin
        // Link and jump in one cycle: the bank sees the PC already advanced by FETCH_WB.
        o_ctrl.reg_dst   = REGDST_RA;
        o_ctrl.data_src  = DSRC_PC;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.pc_source = PCS_JUMP;
        o_ctrl.pc_write  = 1'b1;
      end
      JR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALU_PASS_A;
        o_ctrl.pc_source = PCS_ALU;
        o_ctrl.pc_write  = 1'b1;
      end
      EXC: begin
        o_ctrl.exc       = 1'b1;
        o_ctrl.pc_source = PCS_EXC;
        o_ctrl.pc_write  = (i_wait_cnt == 3'd0);
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multicycle control FSM: state register plus a 3-bit wait counter used for memory
// latency and exception hold; outputs are decoded from the state by ctrl_out_decode.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int EXC_HOLD = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic       MDRWrite,
  output logic       IorD,
  output logic [1:0] RegDst,
  output logic [1:0] DataSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       exc,
  output logic [4:0] state_out
);

  localparam logic [2:0] MEM_LAST = 3'(MEM_WAIT);
  localparam logic [2:0] EXC_LAST = 3'(EXC_HOLD - 1);

  logic [4:0] r_state;
  logic [2:0] r_wait_cnt;
  ctrl_t      w_ctrl;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= RST_ST;
      r_wait_cnt <= '0;
    end else begin
      // Counter clears unless a waiting state explicitly keeps counting.
      r_wait_cnt <= '0;
      case (r_state)
        RST_ST:   r_state <= FETCH;
        FETCH: begin
          if (r_wait_cnt == MEM_LAST) r_state <= FETCH_WB;
          else r_wait_cnt <= r_wait_cnt + 3'd1;
        end
        FETCH_WB: r_state <= DECODE;
        DECODE:   r_state <= decode_next(opcode, funct);
        R_EXEC:   r_state <= (overflow && funct != FN_AND) ? EXC : R_WB;
        ADDI_EXEC: r_state <= overflow ? EXC : ADDI_WB;
        MEM_ADDR: r_state <= (opcode == OP_SW) ? SW_WRITE : LW_READ;
        LW_READ: begin
          if (r_wait_cnt == MEM_LAST) r_state <= LW_MDR;
          else r_wait_cnt <= r_wait_cnt + 3'd1;
        end
        LW_MDR:   r_state <= LW_WB;
        R_WB, ADDI_WB, LW_WB, SW_WRITE, BRANCH, JUMP, JAL, JR: r_state <= FETCH;
        EXC: begin
          if (r_wait_cnt == EXC_LAST) r_state <= FETCH;
          else r_wait_cnt <= r_wait_cnt + 3'd1;
        end
        default:  r_state <= RST_ST;
      endcase
    end
  end

  ctrl_out_decode u_decode (
    .i_state    (r_state),
    .i_opcode   (opcode),
    .i_funct    (funct),
    .i_zero     (zero),
    .i_wait_cnt (r_wait_cnt),
    .o_ctrl     (w_ctrl)
  );

  assign PCWrite     = w_ctrl.pc_write;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign RegWrite    = w_ctrl.reg_write;
  assign ABWrite     = w_ctrl.ab_write;
  assign ALUOutWrite = w_ctrl.alu_out_write;
  assign MDRWrite    = w_ctrl.mdr_write;
  assign IorD        = w_ctrl.iord;
  assign RegDst      = w_ctrl.reg_dst;
  assign DataSrc     = w_ctrl.data_src;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign exc         = w_ctrl.exc;
  assign state_out   = r_state;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: two instances (MEM_WAIT/EXC_HOLD = 1/1 and 2/2), a table of
// per-instruction summaries, hand sequences and random instructions against a trace model.
module tb_cpu_control_unit;
  import cpu_ctrl_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic [5:0] opc [2];
  logic [5:0] fn  [2];
  logic       zr  [2];
  logic       ov  [2];

  typedef struct packed {
    logic       pcw, memw, irw, regw, abw, aluow, mdrw, iord;
    logic [1:0] regdst, datasrc;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       exc;
    logic [4:0] st;
  } obs_t;

  obs_t obs [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      logic w_pcw, w_memw, w_irw, w_regw, w_abw, w_aluow, w_mdrw, w_iord, w_srca, w_exc;
      logic [1:0] w_regdst, w_datasrc, w_srcb, w_pcsrc;
      logic [2:0] w_aluop;
      logic [4:0] w_st;
      cpu_control_unit #(.MEM_WAIT(gi + 1), .EXC_HOLD(gi + 1)) u_dut (
        .clock(clock), .reset(reset), .opcode(opc[gi]), .funct(fn[gi]),
        .zero(zr[gi]), .overflow(ov[gi]),
        .PCWrite(w_pcw), .MemWrite(w_memw), .IRWrite(w_irw), .RegWrite(w_regw),
        .ABWrite(w_abw), .ALUOutWrite(w_aluow), .MDRWrite(w_mdrw), .IorD(w_iord),
        .RegDst(w_regdst), .DataSrc(w_datasrc), .ALUSrcA(w_srca), .ALUSrcB(w_srcb),
        .ALUOp(w_aluop), .PCSource(w_pcsrc), .exc(w_exc), .state_out(w_st)
      );
      assign obs[gi] = {w_pcw, w_memw, w_irw, w_regw, w_abw, w_aluow, w_mdrw, w_iord,
                        w_regdst, w_datasrc, w_srca, w_srcb, w_aluop, w_pcsrc, w_exc, w_st};
    end
  endgenerate

  int errors = 0;
  int checks = 0;
  obs_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Control word expected in a given step of an instruction, from the step's role.
  function automatic obs_t exp_out(input logic [4:0] st, input logic [5:0] op, input logic [5:0] f,
                                   input logic z, input bit first);
    obs_t o;
    o = '0;
    o.st = st;
    case (st)
      FETCH:     begin o.srcb = 2'b01; o.aluop = 3'b001; end
      FETCH_WB:  begin o.srcb = 2'b01; o.aluop = 3'b001; o.irw = 1; o.pcw = 1; end
      DECODE:    begin o.abw = 1; o.aluow = 1; o.srcb = 2'b11; o.aluop = 3'b001; end
      R_EXEC:    begin
        o.srca = 1; o.aluow = 1;
        o.aluop = (f == 6'h22) ? 3'b010 : (f == 6'h24) ? 3'b011 : 3'b001;
      end
      R_WB:      begin o.regdst = 2'b01; o.regw = 1; end
      ADDI_EXEC, MEM_ADDR: begin o.srca = 1; o.srcb = 2'b10; o.aluop = 3'b001; o.aluow = 1; end
      ADDI_WB:   o.regw = 1;
      LW_READ:   o.iord = 1;
      LW_MDR:    begin o.iord = 1; o.mdrw = 1; end
      LW_WB:     begin o.datasrc = 2'b01; o.regw = 1; end
      SW_WRITE:  begin o.iord = 1; o.memw = 1; end
      BRANCH:    begin
        o.srca = 1; o.aluop = 3'b010; o.pcsrc = 2'b01;
        o.pcw = (op == 6'h04) ? z : !z;
      end
      JUMP:      begin o.pcsrc = 2'b10; o.pcw = 1; end
      JAL:       begin o.regdst = 2'b10; o.datasrc = 2'b10; o.regw = 1; o.pcsrc = 2'b10; o.pcw = 1; end
      JR:        begin o.srca = 1; o.pcw = 1; end
      EXC:       begin o.exc = 1; o.pcsrc = 2'b11; o.pcw = first; end
      default:   o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input logic [4:0] st, input logic [5:0] op, input logic [5:0] f,
                      input logic z, input bit first);
    exp_q.push_back(exp_out(st, op, f, z, first));
  endtask

  // Whole-instruction trace from the first FETCH cycle to the last step before the next FETCH.
  task automatic build(input int mw, input int eh, input logic [5:0] op, input logic [5:0] f,
                       input logic z, input logic v);
    bit trap;
    exp_q.delete();
    trap = 0;
    for (int k = 0; k <= mw; k++) push(FETCH, op, f, z, 0);
    push(FETCH_WB, op, f, z, 0);
    push(DECODE, op, f, z, 0);
    if (op == 6'h00 && (f == 6'h20 || f == 6'h22 || f == 6'h24)) begin
      push(R_EXEC, op, f, z, 0);
      if (v && f != 6'h24) trap = 1; else push(R_WB, op, f, z, 0);
    end else if (op == 6'h00 && f == 6'h08) push(JR, op, f, z, 0);
    else if (op == 6'h08) begin
      push(ADDI_EXEC, op, f, z, 0);
      if (v) trap = 1; else push(ADDI_WB, op, f, z, 0);
    end else if (op == 6'h23) begin
      push(MEM_ADDR, op, f, z, 0);
      for (int k = 0; k <= mw; k++) push(LW_READ, op, f, z, 0);
      push(LW_MDR, op, f, z, 0);
      push(LW_WB, op, f, z, 0);
    end else if (op == 6'h2B) begin
      push(MEM_ADDR, op, f, z, 0);
      push(SW_WRITE, op, f, z, 0);
    end else if (op == 6'h04 || op == 6'h05) push(BRANCH, op, f, z, 0);
    else if (op == 6'h02) push(JUMP, op, f, z, 0);
    else if (op == 6'h03) push(JAL, op, f, z, 0);
    else trap = 1;
    if (trap) for (int k = 0; k < eh; k++) push(EXC, op, f, z, k == 0);
  endtask

  task automatic release_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) check($sformatf("rst_st dut%0d", d), 32'(obs[d]), 32'(0));
    @(negedge clock);
  endtask

  // Entered at a negedge; leaves both instances at their first FETCH cycle.
  task automatic do_reset();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) check($sformatf("in_reset dut%0d c%0d", d, c), 32'(obs[d]), 32'(0));
    end
    release_reset();
  endtask

  // Entered at the first FETCH cycle; abort_at>=0 pulls reset mid-instruction at that step.
  task automatic run_instr(input int idx, input logic [5:0] op, input logic [5:0] f,
                           input logic z, input logic v, input int abort_at);
    opc[idx] = op; fn[idx] = f; zr[idx] = z; ov[idx] = v;
    build(idx + 1, idx + 1, op, f, z, v);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs[idx] !== exp_q[i]) begin
        errors++;
        $display("FAIL trace dut%0d op=%h fn=%h z=%0d v=%0d step=%0d: got %h expected %h",
                 idx, op, f, z, v, i, obs[idx], exp_q[i]);
      end
      if (i == abort_at) begin
        #2 reset = 1'b0;
        #1;
        check("abort MemWrite", 32'(obs[idx].memw), 32'(0));
        check("abort state", 32'(obs[idx].st), 32'(RST_ST));
        @(negedge clock);
        release_reset();
        return;
      end
      @(negedge clock);
    end
  endtask

  typedef struct {
    logic [5:0] op, f;
    logic       z, v;
    int         cyc, regw, memw, pcw, excs;
  } vec_t;

  vec_t tbl [18];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops [11];
    logic [5:0] fns [5];
    int cyc, nrw, nmw, npw, nex;
    bit left;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin opc[d] = 6'h00; fn[d] = 6'h20; zr[d] = 0; ov[d] = 0; end

    // Per-instruction summary with MEM_WAIT=1, EXC_HOLD=1: cycles FETCH..FETCH, pulse counts.
    tbl[0]  = '{6'h00, 6'h20, 0, 0, 6, 1, 0, 1, 0};
    tbl[1]  = '{6'h00, 6'h22, 0, 1, 6, 0, 0, 2, 1};
    tbl[2]  = '{6'h00, 6'h24, 0, 1, 6, 1, 0, 1, 0};
    tbl[3]  = '{6'h00, 6'h08, 0, 0, 5, 0, 0, 2, 0};
    tbl[4]  = '{6'h08, 6'h00, 0, 0, 6, 1, 0, 1, 0};
    tbl[5]  = '{6'h08, 6'h00, 0, 1, 6, 0, 0, 2, 1};
    tbl[6]  = '{6'h23, 6'h00, 0, 0, 9, 1, 0, 1, 0};
    tbl[7]  = '{6'h2B, 6'h00, 0, 0, 6, 0, 1, 1, 0};
    tbl[8]  = '{6'h04, 6'h00, 1, 0, 5, 0, 0, 2, 0};
    tbl[9]  = '{6'h04, 6'h00, 0, 0, 5, 0, 0, 1, 0};
    tbl[10] = '{6'h05, 6'h00, 1, 0, 5, 0, 0, 1, 0};
    tbl[11] = '{6'h05, 6'h00, 0, 0, 5, 0, 0, 2, 0};
    tbl[12] = '{6'h02, 6'h00, 0, 0, 5, 0, 0, 2, 0};
    tbl[13] = '{6'h03, 6'h00, 0, 0, 5, 1, 0, 2, 0};
    tbl[14] = '{6'h3F, 6'h00, 0, 0, 5, 0, 0, 2, 1};
    tbl[15] = '{6'h00, 6'h00, 0, 0, 5, 0, 0, 2, 1};
    tbl[16] = '{6'h00, 6'h22, 0, 0, 6, 1, 0, 1, 0};
    tbl[17] = '{6'h00, 6'h20, 0, 1, 6, 0, 0, 2, 1};

    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h00};

    @(negedge clock);
    do_reset();

    // Hand sequence: reset exit then one add on MEM_WAIT=1.
    check("fetch0 st", 32'(obs[0].st), 32'(FETCH));
    @(negedge clock);
    check("fetch1 st", 32'(obs[0].st), 32'(FETCH));
    @(negedge clock);
    check("fetch_wb st", 32'(obs[0].st), 32'(FETCH_WB));
    check("fetch_wb IRWrite", 32'(obs[0].irw), 32'(1));
    check("fetch_wb PCWrite", 32'(obs[0].pcw), 32'(1));
    @(negedge clock);
    check("decode st", 32'(obs[0].st), 32'(DECODE));
    @(negedge clock);
    check("r_exec st", 32'(obs[0].st), 32'(R_EXEC));
    check("r_exec ALUOp", 32'(obs[0].aluop), 32'(3'b001));
    check("r_exec ALUSrcA", 32'(obs[0].srca), 32'(1));
    @(negedge clock);
    check("r_wb st", 32'(obs[0].st), 32'(R_WB));
    check("r_wb RegWrite", 32'(obs[0].regw), 32'(1));
    check("r_wb RegDst", 32'(obs[0].regdst), 32'(2'b01));
    check("r_wb DataSrc", 32'(obs[0].datasrc), 32'(2'b00));
    @(negedge clock);
    check("add done st", 32'(obs[0].st), 32'(FETCH));

    // Table-driven summaries on instance 0.
    for (int t = 0; t < 18; t++) begin
      opc[0] = tbl[t].op; fn[0] = tbl[t].f; zr[0] = tbl[t].z; ov[0] = tbl[t].v;
      cyc = 0; nrw = 0; nmw = 0; npw = 0; nex = 0; left = 0;
      while (cyc < 40) begin
        if (left && obs[0].st == FETCH) break;
        if (obs[0].st != FETCH) left = 1;
        nrw += int'(obs[0].regw); nmw += int'(obs[0].memw);
        npw += int'(obs[0].pcw);  nex += int'(obs[0].exc);
        cyc++;
        @(negedge clock);
      end
      check($sformatf("tbl%0d cycles", t), 32'(cyc), 32'(tbl[t].cyc));
      check($sformatf("tbl%0d RegWrite", t), 32'(nrw), 32'(tbl[t].regw));
      check($sformatf("tbl%0d MemWrite", t), 32'(nmw), 32'(tbl[t].memw));
      check($sformatf("tbl%0d PCWrite", t), 32'(npw), 32'(tbl[t].pcw));
      check($sformatf("tbl%0d exc", t), 32'(nex), 32'(tbl[t].excs));
      if (cyc >= 40) begin
        do_reset();
      end
    end

    // Reset asserted during SW_WRITE (step 5 with MEM_WAIT=1).
    run_instr(0, 6'h2B, 6'h00, 0, 0, 5);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      op = (n % 7 == 6) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 10)];
      run_instr(0, op, fns[$urandom_range(0, 4)], 1'($urandom), 1'($urandom), -1);
    end

    @(negedge clock);
    do_reset();

    // Load with MEM_WAIT=2 on instance 1.
    opc[1] = 6'h23; fn[1] = 6'h00; zr[1] = 0; ov[1] = 0;
    cyc = 0;
    for (int s = 0; s < 12; s++) begin
      if (s < 3) check($sformatf("lw s%0d st", s), 32'(obs[1].st), 32'(FETCH));
      if (s == 5) check("lw mem_addr st", 32'(obs[1].st), 32'(MEM_ADDR));
      if (s >= 6 && s <= 8) begin
        check($sformatf("lw read%0d st", s - 6), 32'(obs[1].st), 32'(LW_READ));
        check($sformatf("lw read%0d IorD", s - 6), 32'(obs[1].iord), 32'(1));
      end
      if (s == 9) begin
        check("lw_mdr st", 32'(obs[1].st), 32'(LW_MDR));
        check("lw_mdr MDRWrite", 32'(obs[1].mdrw), 32'(1));
      end
      if (s == 10) begin
        check("lw_wb st", 32'(obs[1].st), 32'(LW_WB));
        check("lw_wb DataSrc", 32'(obs[1].datasrc), 32'(2'b01));
        check("lw_wb RegDst", 32'(obs[1].regdst), 32'(2'b00));
        check("lw_wb RegWrite", 32'(obs[1].regw), 32'(1));
      end
      if (s == 11) check("lw done st", 32'(obs[1].st), 32'(FETCH));
      if (s < 11) @(negedge clock);
    end

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      op = (n % 7 == 6) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 10)];
      run_instr(1, op, fns[$urandom_range(0, 4)], 1'($urandom), 1'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
